// File: rtl/tt_hsig_link_host.sv
// tt_hsig_link_host: chip-side master for the single-wire half-duplex cell link.
// Sends a start bit and a command byte, LSB first. For read commands it then
// releases the wire and receives a start bit and a response byte from the far end.
// All pad controls are registered. pad_y is brought in through a 2-flop synchronizer.
module tt_hsig_link_host #(
  parameter int unsigned CLKDIV       = 8,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_read,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  input  logic       pad_y,
  output logic       pad_a,
  output logic       pad_oe,
  output logic       pad_ie,
  output logic       pad_sl,
  output logic       pad_cs,
  output logic       pad_pd,
  output logic       pad_pu
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_TX     = 3'd2,
    S_TURN   = 3'd3,
    S_WAIT   = 3'd4,
    S_RSTART = 3'd5,
    S_RX     = 3'd6,
    S_GUARD  = 3'd7
  } state_t;

  localparam logic [7:0] BIT_LAST = 8'(CLKDIV - 1);
  localparam logic [7:0] BIT_MID  = 8'(CLKDIV / 2);
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_BITS);

  state_t     state_q, state_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       read_q, read_d;
  logic       y_meta_q, y_s_q;
  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic       pad_a_q, pad_a_d;
  logic       pad_oe_q, pad_oe_d;
  logic       bit_end_s, bit_mid_s;

  // Fixed pad configuration: input always enabled so the host sees its own drive.
  assign pad_ie = 1'b1;
  assign pad_sl = 1'b0;
  assign pad_cs = 1'b1;
  assign pad_pd = 1'b0;
  assign pad_pu = 1'b1;

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign pad_a     = pad_a_q;
  assign pad_oe    = pad_oe_q;

  assign bit_end_s = (bit_cnt_q == BIT_LAST);
  assign bit_mid_s = (bit_cnt_q == BIT_MID);

  // Two-flop synchronizer for the asynchronous pad input; idles high like the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_meta_q <= 1'b1;
      y_s_q    <= 1'b1;
    end else begin
      y_meta_q <= pad_y;
      y_s_q    <= y_meta_q;
    end
  end

  // Next-state, bit timing, shift registers and registered outputs for the link FSM.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_end_s ? 8'd0 : (bit_cnt_q + 8'd1);
    bit_idx_d   = bit_idx_q;
    to_cnt_d    = to_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    read_d      = read_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = 8'd0;
        if (cmd_valid && cmd_ready_q) begin
          state_d    = S_START;
          tx_shift_d = cmd_data;
          read_d     = cmd_read;
          bit_idx_d  = 3'd0;
          to_cnt_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_TX;
        end else begin
          state_d = S_START;
        end
      end
      S_TX: begin
        if (bit_end_s) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = read_q ? S_TURN : S_GUARD;
          end else begin
            state_d = S_TX;
          end
        end else begin
          state_d = S_TX;
        end
      end
      S_TURN: begin
        // One released bit lets the wire (and y_s) settle high before we look for a start bit.
        if (bit_end_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_TURN;
        end
      end
      S_WAIT: begin
        if (!y_s_q) begin
          state_d   = S_RSTART;
          bit_cnt_d = 8'd0;
        end else if (bit_end_s) begin
          to_cnt_d = to_cnt_q + 8'd1;
          if ((to_cnt_q + 8'd1) == TO_LIMIT) begin
            state_d     = S_GUARD;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 8'h00;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RSTART: begin
        // A start bit that is high again at mid-bit was a glitch; keep the timeout count running.
        if (bit_mid_s && y_s_q) begin
          state_d   = S_WAIT;
          bit_cnt_d = 8'd0;
        end else if (bit_end_s) begin
          state_d   = S_RX;
          bit_idx_d = 3'd0;
        end else begin
          state_d = S_RSTART;
        end
      end
      S_RX: begin
        if (bit_mid_s) begin
          rx_shift_d = {y_s_q, rx_shift_q[7:1]};
        end else begin
          rx_shift_d = rx_shift_q;
        end
        if (bit_end_s) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d     = S_GUARD;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = rx_shift_q;
          end else begin
            state_d = S_RX;
          end
        end else begin
          state_d = S_RX;
        end
      end
      S_GUARD: begin
        if (bit_end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GUARD;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = 8'd0;
      end
    endcase

    // Pad and handshake outputs are decoded from the next state so they switch with it.
    case (state_d)
      S_START: begin
        pad_oe_d = 1'b1;
        pad_a_d  = 1'b0;
      end
      S_TX: begin
        pad_oe_d = 1'b1;
        pad_a_d  = tx_shift_d[0];
      end
      default: begin
        pad_oe_d = 1'b0;
        pad_a_d  = 1'b1;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = !cmd_ready_d;
  end

  // State, counters, data path and output registers; any reset aborts the frame and frees the pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 8'd0;
      bit_idx_q   <= 3'd0;
      to_cnt_q    <= 8'd0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      read_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      pad_a_q     <= 1'b1;
      pad_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      to_cnt_q    <= to_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      read_q      <= read_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      pad_a_q     <= pad_a_d;
      pad_oe_q    <= pad_oe_d;
    end
  end

endmodule

// File: tb/tb_tt_hsig_link_host.sv
// Directed testbench for tt_hsig_link_host (CLKDIV=8, TIMEOUT_BITS=16).
// Positions are counted in falling edges after the command-accept rising edge.
module tb_tt_hsig_link_host;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_read;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       pad_y;
  logic       pad_a, pad_oe, pad_ie, pad_sl, pad_cs, pad_pd, pad_pu;

  logic       resp_en;
  logic       resp_bit;

  int         errors;
  int         checks;
  int         rsp_cnt;
  logic [7:0] rsp_d_cap;
  logic       rsp_e_cap;
  int         base_cnt;

  tt_hsig_link_host #(.CLKDIV(8), .TIMEOUT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_read(cmd_read),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .pad_y(pad_y), .pad_a(pad_a), .pad_oe(pad_oe), .pad_ie(pad_ie),
    .pad_sl(pad_sl), .pad_cs(pad_cs), .pad_pd(pad_pd), .pad_pu(pad_pu)
  );

  // Wire model: host drives when oe=1, otherwise the responder or the pull-up.
  assign pad_y = pad_oe ? pad_a : (resp_en ? resp_bit : 1'b1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every rsp_valid pulse with its data and error flag.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt   = rsp_cnt + 1;
      rsp_d_cap = rsp_data;
      rsp_e_cap = rsp_err;
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one command for a single cycle; returns at position 0 of the frame.
  task automatic accept(input logic [7:0] d, input logic rd);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_read  = rd;
    step(1);
    cmd_valid = 1'b0;
    chk1("accept_ready_low", cmd_ready, 1'b0);
    chk1("accept_busy", busy, 1'b1);
  endtask

  // From position 0, check start bit, 8 data bits, release and the return of cmd_ready at 80.
  task automatic tx_check(input logic [7:0] b);
    logic [8:0] bits;
    bits = {b, 1'b0};
    step(4);
    for (int k = 0; k < 9; k++) begin
      chk1("tx_oe", pad_oe, 1'b1);
      chk1("tx_a", pad_a, bits[k]);
      if (k < 8) step(8);
    end
    step(4);
    chk1("guard_oe", pad_oe, 1'b0);
    chk1("guard_a", pad_a, 1'b1);
    step(7);
    chk1("ready_at_79", cmd_ready, 1'b0);
    step(1);
    chk1("ready_at_80", cmd_ready, 1'b1);
  endtask

  // Drive start bit plus a byte LSB first, 8 cycles per bit, checking the host stays off the wire.
  task automatic responder(input logic [7:0] r);
    logic [8:0] bits;
    bits = {r, 1'b0};
    for (int k = 0; k < 9; k++) begin
      resp_en  = 1'b1;
      resp_bit = bits[k];
      step(4);
      chk1("rx_oe_low", pad_oe, 1'b0);
      step(4);
    end
    resp_en = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge clk);
    chk1("wait_idle", cmd_ready, 1'b1);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rsp_cnt   = 0;
    rsp_d_cap = 8'h00;
    rsp_e_cap = 1'b0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_read  = 1'b0;
    resp_en   = 1'b0;
    resp_bit  = 1'b1;

    // Reset values
    #23;
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk8("rst_rsp_data", rsp_data, 8'h00);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_pad_a", pad_a, 1'b1);
    chk1("rst_pad_oe", pad_oe, 1'b0);
    chk1("rst_pad_ie", pad_ie, 1'b1);
    chk1("rst_pad_pu", pad_pu, 1'b1);
    chk1("pad_sl", pad_sl, 1'b0);
    chk1("pad_cs", pad_cs, 1'b1);
    chk1("pad_pd", pad_pd, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Write 0xA5
    accept(8'hA5, 1'b0);
    tx_check(8'hA5);
    chk8("write_no_rsp", 8'(rsp_cnt), 8'd0);

    // Read 0x3C; responder answers 0x5A three bit periods after TURN ends (WAIT entry at 80)
    base_cnt = rsp_cnt;
    accept(8'h3C, 1'b1);
    step(104);
    responder(8'h5A);
    wait_idle();
    chk8("read_rsp_count", 8'(rsp_cnt - base_cnt), 8'd1);
    chk8("read_rsp_data", rsp_d_cap, 8'h5A);
    chk1("read_rsp_err", rsp_e_cap, 1'b0);
    chk8("read_rsp_data_held", rsp_data, 8'h5A);

    // Read with silent responder: timeout 16 bits after WAIT entry at position 80
    base_cnt = rsp_cnt;
    accept(8'h00, 1'b1);
    step(207);
    chk1("to_not_yet", rsp_valid, 1'b0);
    step(1);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_rsp_err", rsp_err, 1'b1);
    chk8("to_rsp_data", rsp_data, 8'h00);
    step(1);
    chk1("to_pulse_one_cycle", rsp_valid, 1'b0);
    step(6);
    chk1("to_ready_215", cmd_ready, 1'b0);
    step(1);
    chk1("to_ready_216", cmd_ready, 1'b1);
    chk8("to_rsp_count", 8'(rsp_cnt - base_cnt), 8'd1);

    // Glitch during WAIT, then a valid 0x81 response
    base_cnt = rsp_cnt;
    accept(8'h55, 1'b1);
    step(96);
    resp_en  = 1'b1;
    resp_bit = 1'b0;
    step(2);
    resp_en  = 1'b0;
    step(22);
    chk8("glitch_no_rsp", 8'(rsp_cnt - base_cnt), 8'd0);
    responder(8'h81);
    wait_idle();
    chk8("glitch_rsp_count", 8'(rsp_cnt - base_cnt), 8'd1);
    chk8("glitch_rsp_data", rsp_d_cap, 8'h81);
    chk1("glitch_rsp_err", rsp_e_cap, 1'b0);

    // Reset during data bit 3 of 0xFF
    base_cnt = rsp_cnt;
    accept(8'hFF, 1'b0);
    step(36);
    chk1("pre_rst_oe", pad_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("midrst_oe", pad_oe, 1'b0);
    chk1("midrst_a", pad_a, 1'b1);
    chk1("midrst_ready", cmd_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk8("midrst_rsp_data", rsp_data, 8'h00);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk8("midrst_no_rsp", 8'(rsp_cnt - base_cnt), 8'd0);
    accept(8'h96, 1'b0);
    tx_check(8'h96);

    // Back-to-back: cmd_valid held high across two writes
    base_cnt  = rsp_cnt;
    cmd_valid = 1'b1;
    cmd_data  = 8'h3A;
    cmd_read  = 1'b0;
    step(1);
    chk1("b2b_first_accept", cmd_ready, 1'b0);
    cmd_data = 8'hC5;
    tx_check(8'h3A);
    step(1);
    cmd_valid = 1'b0;
    chk1("b2b_second_accept", cmd_ready, 1'b0);
    tx_check(8'hC5);
    chk8("b2b_no_rsp", 8'(rsp_cnt - base_cnt), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_hsig_link_host.md
Name: tt_hsig_link_host

Overview:
- Chip-side host for the single-wire half-duplex signal link used by the cell macros.
- Drives the full pad control bundle (A, OE, IE, SL, CS, PD, PU) and samples the pad Y input.
- Transmits a command byte to the far-end cell and, for read commands, releases the wire and receives a one-byte response.
- Sits between the controller logic and a bidirectional pad cell.

Parameters:
- CLKDIV, 8: clk cycles per link bit; legal 4..255; must be even.
- TIMEOUT_BITS, 16: bit periods to wait for the responder start bit before flagging an error; legal 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  host idle and able to accept a command
- cmd_data  input  8  byte to transmit
- cmd_read  input  1  1 = expect a response byte after transmit
- rsp_valid  output  1  one-cycle pulse when a read completes
- rsp_data  output  8  received byte; held until the next rsp_valid
- rsp_err  output  1  qualifies rsp_valid; 1 = timeout, and rsp_data = 0x00
- busy  output  1  frame in progress
- pad_y  input  1  pad input buffer output (asynchronous)
- pad_a  output  1  pad output data
- pad_oe  output  1  pad output enable
- pad_ie  output  1  pad input enable
- pad_sl  output  1  slew select; constant 0 (slow)
- pad_cs  output  1  Schmitt select; constant 1
- pad_pd  output  1  pull-down enable; constant 0
- pad_pu  output  1  pull-up enable

Behaviour:
- Clock and reset: one clock domain, clk; reset is asynchronous and active-low on rst_n. Every flop resets asynchronously.
- Reset values:
  - Outputs: cmd_ready=1, rsp_valid=0, rsp_data=0x00, rsp_err=0, busy=0.
  - Pads: pad_a=1, pad_oe=0, pad_ie=1, pad_pu=1.
  - Internal: state=IDLE, all counters 0.
  - Reset asserted mid-frame aborts immediately. The pad is released (oe=0) with no rsp_valid emitted.
- Input synchronisation:
  - pad_y passes through a 2-flop synchronizer; all receive logic uses the synchronized value y_s (2-cycle latency).
  - The synchronizer resets to 1.
- Bit timer:
  - bit_cnt counts 0..CLKDIV-1 and wraps; it restarts at 0 on every state entry.
  - The "mid" sample point is bit_cnt == CLKDIV/2.
- Command handshake:
  - A command is accepted on the clk edge where cmd_valid && cmd_ready; cmd_data and cmd_read are latched then.
  - cmd_ready=1 only in IDLE. It drops the cycle after acceptance.
  - busy = !cmd_ready.
- State machine (each bit state lasts exactly CLKDIV cycles unless noted):
  - IDLE: oe=0, pu=1. On accept, go to START.
  - START: oe=1, a=0 for one bit.
  - TX: oe=1, a=shift[0], 8 bits LSB first; shift right at the end of each bit.
    - After bit 7: if the latched read=0, go to GUARD; otherwise go to TURN.
  - TURN: oe=0, pu=1 for one bit; the wire floats high.
  - WAIT:
    - oe=0. Each cycle, if y_s==0, go to RSTART with bit_cnt=0.
    - An internal timeout counter counts completed bit periods. When it reaches TIMEOUT_BITS, go to GUARD with a timeout flag set.
  - RSTART: one bit; at mid, y_s must be 0.
    - If y_s=1 at mid (glitch), return to WAIT. The timeout count is not reset.
  - RX: 8 bits; at each mid, shift y_s into bit 7 of the receive register (LSB first on the wire).
    - After bit 7, set rsp_data to the received byte, pulse rsp_valid with rsp_err=0, and go to GUARD.
  - GUARD: oe=0 for one bit (idle-high recovery), then go to IDLE.
    - On entry with the timeout flag set, pulse rsp_valid with rsp_err=1 and rsp_data=0x00.
- rsp_valid is a registered output. It pulses for exactly one cycle per read command, never for write-only commands.
- Frame length in cycles, accept edge to cmd_ready=1:
  - Write: (1+8+1)*CLKDIV.
  - Read: depends on the responder.
- pad_ie stays 1 at all times, so the host can observe its own transmission. pad_a is forced to 1 whenever oe=0.
- cmd_valid while busy is ignored; it is not queued.

Test Plan:
- Write 0xA5, CLKDIV=8, cmd_read=0:
  - pad_a/oe show start 0 then bits 1,0,1,0,0,1,0,1, each 8 cycles.
  - oe falls after bit 7; cmd_ready returns 80 cycles after accept; no rsp_valid.
- Read with cmd 0x3C; a responder model drives start then 0x5A, beginning 3 bits after TURN:
  - rsp_valid pulses once with rsp_data=0x5A, rsp_err=0.
  - pad_oe=0 throughout response reception.
- Read with the responder silent, TIMEOUT_BITS=16:
  - rsp_valid pulses 16 bit periods after WAIT entry with rsp_err=1, rsp_data=0x00.
  - cmd_ready returns one bit period later.
- Responder glitch: a 2-cycle low pulse during WAIT, then a valid response 0x81:
  - The glitch is rejected at mid-sample; the response is later received as 0x81, rsp_err=0.
- Reset mid-TX: rst_n low during bit 3 of 0xFF:
  - Outputs immediately reach their reset values (oe=0, a=1, cmd_ready=1).
  - No rsp_valid; the next command transmits normally.
- Back-to-back commands: hold cmd_valid high with two commands:
  - The second command is accepted on the first IDLE cycle after GUARD; the data on the wire matches both bytes in order.
